// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS32 memory arbiter slice.
//   req_id_t : which requester owns a grant or an outstanding read
//   state_t  : arbiter FSM states
//   DW       : default data width
//   is_read_grant() : tells the FSM whether a grant starts a read
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_LD   = 2'd1,
        REQ_DM   = 2'd2,
        REQ_IF   = 2'd3
    } req_id_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // Loader grants are always writes and fetch grants are always reads;
    // only a data grant needs the write-enable to decide.
    function automatic logic is_read_grant(req_id_t id, logic we);
        return (id == REQ_IF) || ((id == REQ_DM) && !we);
    endfunction

endpackage

// File: rtl/mips_arb_prio.sv
// ---------------------------------------------------------------------------
// mips_arb_prio
// Combinational fixed-priority picker for the memory arbiter.
// Ports:
//   ld_req, dm_req, if_req : requests, already masked by the caller
//   starve                 : fetch has been denied long enough to jump DM
//   winner_id              : req_id_t code of the winner (REQ_NONE if idle)
// Normal order is LD > DM > IF; with starve set it becomes LD > IF > DM.
// ---------------------------------------------------------------------------
module mips_arb_prio
    import mips_pkg::*;
(
    input  logic       ld_req,
    input  logic       dm_req,
    input  logic       if_req,
    input  logic       starve,
    output logic [1:0] winner_id
);

    // The loader only runs before the core starts, so it is allowed to
    // hold off everyone else indefinitely.
    always_comb begin
        winner_id = REQ_NONE;
        if (ld_req) begin
            winner_id = REQ_LD;
        end else if (starve && if_req) begin
            winner_id = REQ_IF;
        end else if (dm_req) begin
            winner_id = REQ_DM;
        end else if (if_req) begin
            winner_id = REQ_IF;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
// Shares one single-port synchronous memory between the program loader (LD),
// the MEM-stage load/store unit (DM) and instruction fetch (IF).
// Ports:
//   clk1, rst_n          : clock (rising edge), async active-low reset
//   halted               : core halted; fetch requests are ignored
//   ld_req/addr/wdata    : loader write request, ld_gnt when it is written
//   dm_req/we/addr/wdata : data request, dm_gnt on grant,
//                          dm_rvalid/dm_rdata for load data
//   if_req/addr          : fetch request, if_gnt on grant,
//                          if_rvalid/if_rdata for the instruction
//   mem_en/we/addr/wdata : registered memory strobe and fields
//   mem_rdata            : memory data, valid MEM_LAT cycles after mem_en
//   busy                 : a read is outstanding
// Optional build macro MEM_ARB_PERF_EN adds perf_if_stall / perf_dm_stall.
// ---------------------------------------------------------------------------
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = mips_pkg::DW,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          halted,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_if_stall,
    output logic [31:0]   perf_dm_stall
`endif
);

    localparam int LCW = $clog2(MEM_LAT + 1);
    localparam int SCW = $clog2(STARVE_LIM + 1);

    state_t          state_q,     state_d;
    logic [LCW-1:0]  lat_cnt_q,   lat_cnt_d;
    req_id_t         owner_q,     owner_d;
    req_id_t         gnt_id_q,    gnt_id_d;
    logic            mem_en_q,    mem_en_d;
    logic            mem_we_q,    mem_we_d;
    logic [AW-1:0]   mem_addr_q,  mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SCW-1:0]  starve_cnt_q, starve_cnt_d;
    logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;
    logic [DW-1:0]   if_rdata_q,  if_rdata_d;

    logic            if_req_m;
    logic            starve;
    logic [1:0]      winner_raw;
    req_id_t         winner;
    logic            rd_done;
    logic            eval;

    assign if_req_m = if_req && !halted;
    assign starve   = (starve_cnt_q == SCW'(STARVE_LIM));
    assign winner   = req_id_t'(winner_raw);

    mips_arb_prio u_prio (
        .ld_req    (ld_req),
        .dm_req    (dm_req),
        .if_req    (if_req_m),
        .starve    (starve),
        .winner_id (winner_raw)
    );

    // The requester still holds its request during its own grant cycle, so
    // no evaluation happens then. The last RD_WAIT cycle (the rvalid cycle)
    // is an evaluation so the next grant lands right after the read data.
    assign rd_done = (state_q == RD_WAIT) && (lat_cnt_q == LCW'(MEM_LAT));
    assign eval    = ((state_q == IDLE) && (gnt_id_q == REQ_NONE)) || rd_done;

    // Register the winner's fields; mem_* read as zero outside grant cycles.
    always_comb begin
        gnt_id_d    = REQ_NONE;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (eval) begin
            unique case (winner)
                REQ_LD: begin
                    gnt_id_d    = REQ_LD;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ld_addr;
                    mem_wdata_d = ld_wdata;
                end
                REQ_DM: begin
                    gnt_id_d    = REQ_DM;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end
                REQ_IF: begin
                    gnt_id_d    = REQ_IF;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = if_addr;
                end
                default: begin
                    gnt_id_d    = REQ_NONE;
                end
            endcase
        end
    end

    // A read grant moves to RD_WAIT after the grant cycle; lat_cnt counts
    // the cycles since the grant, and the owner is remembered for rvalid.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        unique case (state_q)
            IDLE: begin
                if (is_read_grant(gnt_id_q, mem_we_q)) begin
                    state_d   = RD_WAIT;
                    lat_cnt_d = LCW'(1);
                    owner_d   = gnt_id_q;
                end
            end
            RD_WAIT: begin
                if (rd_done) begin
                    state_d   = IDLE;
                    lat_cnt_d = '0;
                    owner_d   = REQ_NONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetch starvation only moves on evaluation cycles, so requests that
    // arrive while a read is outstanding do not age the counter.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (eval) begin
            if (!if_req_m || (winner == REQ_IF)) begin
                starve_cnt_d = '0;
            end else if (!starve) begin
                starve_cnt_d = starve_cnt_q + SCW'(1);
            end
        end
    end

    // Read data passes straight through in the rvalid cycle and is held
    // afterwards; only rvalid qualifies it.
    always_comb begin
        dm_rdata_d = dm_rdata_q;
        if_rdata_d = if_rdata_q;
        if (dm_rvalid) begin
            dm_rdata_d = mem_rdata;
        end
        if (if_rvalid) begin
            if_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            owner_q      <= REQ_NONE;
            gnt_id_q     <= REQ_NONE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            starve_cnt_q <= '0;
            dm_rdata_q   <= '0;
            if_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            owner_q      <= owner_d;
            gnt_id_q     <= gnt_id_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            starve_cnt_q <= starve_cnt_d;
            dm_rdata_q   <= dm_rdata_d;
            if_rdata_q   <= if_rdata_d;
        end
    end

    assign ld_gnt    = (gnt_id_q == REQ_LD);
    assign dm_gnt    = (gnt_id_q == REQ_DM);
    assign if_gnt    = (gnt_id_q == REQ_IF);
    assign dm_rvalid = rd_done && (owner_q == REQ_DM);
    assign if_rvalid = rd_done && (owner_q == REQ_IF);
    assign dm_rdata  = dm_rdata_d;
    assign if_rdata  = if_rdata_d;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == RD_WAIT);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall_q, perf_if_stall_d;
    logic [31:0] perf_dm_stall_q, perf_dm_stall_d;
    logic        if_stall;
    logic        dm_stall;

    // A cycle is a stall when the request is up but it neither wins this
    // cycle's evaluation nor is in its own grant cycle.
    assign if_stall = if_req_m && !(eval && (winner == REQ_IF)) && (gnt_id_q != REQ_IF);
    assign dm_stall = dm_req   && !(eval && (winner == REQ_DM)) && (gnt_id_q != REQ_DM);

    always_comb begin
        perf_if_stall_d = perf_if_stall_q;
        perf_dm_stall_d = perf_dm_stall_q;
        if (if_stall && (perf_if_stall_q != '1)) begin
            perf_if_stall_d = perf_if_stall_q + 32'd1;
        end
        if (dm_stall && (perf_dm_stall_q != '1)) begin
            perf_dm_stall_d = perf_dm_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall_q <= '0;
            perf_dm_stall_q <= '0;
        end else begin
            perf_if_stall_q <= perf_if_stall_d;
            perf_dm_stall_q <= perf_dm_stall_d;
        end
    end

    assign perf_if_stall = perf_if_stall_q;
    assign perf_dm_stall = perf_dm_stall_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_arbiter
// Directed bench for mips_mem_arbiter with a behavioural memory behind it.
// Read expectations come from a reference image of memory kept by the bench
// and are queued when a read request is driven, then consumed on rvalid.
// Build with MEM_ARB_PERF_EN defined to include the stall-counter step.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_mem_arbiter;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int MEM_LAT    = 1;
    localparam int STARVE_LIM = 4;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          halted;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_if_stall;
    logic [31:0]   perf_dm_stall;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW-1:0] dm_exp_q[$];
    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    mips_mem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .halted(halted),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall)
`endif
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word_of(input int a);
        return (a == 0) ? 32'h2801_0078 : (32'hA500_0000 | 32'(a));
    endfunction

    // Behavioural single-port memory: unwritten words hold word_of(addr),
    // read data appears MEM_LAT cycles after mem_en.
    logic [DW-1:0] dev_mem [0:(1<<AW)-1];
    bit            dev_wr  [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:MEM_LAT-1];

    always @(posedge clk1) begin
        rd_pipe[0] <= (mem_en && !mem_we)
                      ? (dev_wr[mem_addr] ? dev_mem[mem_addr] : word_of(int'(mem_addr)))
                      : 32'hDEAD_BEEF;
        for (int s = 1; s < MEM_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
        if (mem_en && mem_we) begin
            dev_mem[mem_addr] = mem_wdata;
            dev_wr[mem_addr]  = 1'b1;
        end
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // who: 0=LD, 1=DM, 2=IF. track=0 drives a request without queuing data.
    task automatic applyStimulus(input int who, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input bit track);
        case (who)
            0: begin
                ld_req = 1'b1; ld_addr = addr; ld_wdata = data;
                ref_mem[addr] = data;
            end
            1: begin
                dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = data;
                if (we) ref_mem[addr] = data;
                else if (track) dm_exp_q.push_back(ref_mem[addr]);
            end
            default: begin
                if_req = 1'b1; if_addr = addr;
                if (track) if_exp_q.push_back(ref_mem[addr]);
            end
        endcase
    endtask

    task automatic stepCycle();
        @(posedge clk1);
        #1;
    endtask

    function automatic logic anyOut();
        return |{ld_gnt, dm_gnt, dm_rvalid, dm_rdata, if_gnt, if_rvalid, if_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata, busy};
    endfunction

    task automatic drain();
        for (int c = 0; c < 20 && (dm_exp_q.size() != 0 || if_exp_q.size() != 0); c++)
            stepCycle();
        checkOutput("scoreboard_drained", 32'(dm_exp_q.size() + if_exp_q.size()), 32'd0);
        stepCycle();
        stepCycle();
    endtask

    // Read-return monitor: every rvalid must match the oldest queued value.
    always @(negedge clk1) begin
        if (dm_rvalid) begin
            if (dm_exp_q.size() == 0) checkOutput("dm_rvalid_unexpected", 32'd1, 32'd0);
            else checkOutput("dm_rdata_sb", dm_rdata, dm_exp_q.pop_front());
        end
        if (if_rvalid) begin
            if (if_exp_q.size() == 0) checkOutput("if_rvalid_unexpected", 32'd1, 32'd0);
            else checkOutput("if_rdata_sb", if_rdata, if_exp_q.pop_front());
        end
    end

    initial begin : main
        int nLd, nDmG, opIdx, maxStarve, n;
        int dmGntCyc, dmRvCyc, ifGntCyc;
        bit sawIf, done, bad, sawRv;
        logic opWe [5];
        logic [AW-1:0] opAddr [5];
        logic [DW-1:0] opData [5];

        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = word_of(i);
        rst_n = 1'b0; halted = 1'b0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        if_req = 1'b0; if_addr = '0;

        #12;
        checkOutput("reset_outputs", 32'(anyOut()), 32'd0);
        #2 rst_n = 1'b1;
        stepCycle();
        stepCycle();

        // Loader writes take priority over a pending fetch.
        $display("[TB] loader writes with fetch pending");
        applyStimulus(2, 1'b0, 10'd0, '0, 1'b1);
        applyStimulus(0, 1'b1, 10'd120, 32'd40, 1'b1);
        nLd = 0; sawIf = 1'b0;
        for (int c = 0; c < 20 && nLd < 2; c++) begin
            stepCycle();
            if (if_gnt) sawIf = 1'b1;
            if (ld_gnt) begin
                checkOutput("ld_mem_we", 32'(mem_we), 32'd1);
                checkOutput("ld_mem_addr", 32'(mem_addr), (nLd == 0) ? 32'd120 : 32'd240);
                checkOutput("ld_mem_wdata", mem_wdata, (nLd == 0) ? 32'd40 : 32'd80);
                nLd++;
                if (nLd == 1) applyStimulus(0, 1'b1, 10'd240, 32'd80, 1'b1);
                else ld_req = 1'b0;
            end
        end
        checkOutput("ld_grant_count", 32'(nLd), 32'd2);
        checkOutput("ld_before_if", 32'(sawIf), 32'd0);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            stepCycle();
            if (if_gnt) begin
                done = 1'b1;
                checkOutput("if_gnt_mem_we", 32'(mem_we), 32'd0);
                if_req = 1'b0;
            end
        end
        checkOutput("if_gnt_after_ld", 32'(done), 32'd1);
        drain();

        // Lone fetch: grant one cycle after the request, data one cycle later.
        $display("[TB] lone fetch timing");
        applyStimulus(2, 1'b0, 10'd0, '0, 1'b1);
        stepCycle();
        checkOutput("lone_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("lone_mem_en", 32'(mem_en), 32'd1);
        checkOutput("lone_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("lone_busy_gnt", 32'(busy), 32'd0);
        if_req = 1'b0;
        stepCycle();
        checkOutput("lone_if_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("lone_if_rdata", if_rdata, 32'h2801_0078);
        checkOutput("lone_busy_rv", 32'(busy), 32'd1);
        stepCycle();
        checkOutput("lone_busy_after", 32'(busy), 32'd0);
        checkOutput("lone_rvalid_after", 32'(if_rvalid), 32'd0);
        drain();

        // DM load and fetch in the same cycle: DM first, IF right after data.
        $display("[TB] DM load vs fetch");
        applyStimulus(1, 1'b0, 10'd120, '0, 1'b1);
        applyStimulus(2, 1'b0, 10'd4, '0, 1'b1);
        dmGntCyc = -1; dmRvCyc = -1; ifGntCyc = -1;
        for (int c = 0; c < 20 && ifGntCyc < 0; c++) begin
            stepCycle();
            if (dm_gnt) begin
                dmGntCyc = cyc;
                checkOutput("dm_lw_addr", 32'(mem_addr), 32'd120);
                dm_req = 1'b0;
            end
            if (dm_rvalid) begin
                dmRvCyc = cyc;
                checkOutput("dm_lw_data", dm_rdata, 32'd40);
            end
            if (if_gnt) begin
                ifGntCyc = cyc;
                if_req = 1'b0;
            end
        end
        checkOutput("dm_before_if", 32'((dmGntCyc >= 0) && (dmGntCyc < ifGntCyc)), 32'd1);
        checkOutput("if_after_dm_rvalid", 32'(ifGntCyc), 32'(dmRvCyc + 1));
        drain();

        // Continuous DM traffic must not starve fetch past STARVE_LIM denials.
        $display("[TB] fetch starvation guard");
        opWe   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        opAddr = '{10'd300, 10'd300, 10'd301, 10'd120, 10'd302};
        opData = '{32'h0000_00A1, 32'd0, 32'h0000_00B2, 32'd0, 32'h0000_00C3};
        applyStimulus(2, 1'b0, 10'd8, '0, 1'b1);
        opIdx = 0; nDmG = 0; maxStarve = 0; done = 1'b0;
        applyStimulus(1, opWe[0], opAddr[0], opData[0], 1'b1);
        for (int c = 0; c < 80 && !(opIdx == 5 && done); c++) begin
            stepCycle();
            if (int'(dut.starve_cnt_q) > maxStarve) maxStarve = int'(dut.starve_cnt_q);
            if (dm_gnt) begin
                if (!done) nDmG++;
                opIdx++;
                if (opIdx < 5) applyStimulus(1, opWe[opIdx], opAddr[opIdx], opData[opIdx], 1'b1);
                else dm_req = 1'b0;
            end
            if (if_gnt) begin
                done = 1'b1;
                if_req = 1'b0;
                checkOutput("starve_cleared", 32'(dut.starve_cnt_q), 32'd0);
            end
        end
        checkOutput("starve_if_granted", 32'(done), 32'd1);
        checkOutput("starve_dm_grants", 32'(nDmG), 32'(STARVE_LIM));
        checkOutput("starve_peak", 32'(maxStarve), 32'(STARVE_LIM));
        drain();

        // Halted core: fetch never granted and never ages.
        $display("[TB] halted fetch masking");
        halted = 1'b1;
        applyStimulus(2, 1'b0, 10'd12, '0, 1'b0);
        sawIf = 1'b0; bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            if (if_gnt) sawIf = 1'b1;
            if (dut.starve_cnt_q != 0) bad = 1'b1;
        end
        checkOutput("halted_no_if_gnt", 32'(sawIf), 32'd0);
        checkOutput("halted_starve_zero", 32'(bad), 32'd0);
        if_req = 1'b0;
        stepCycle();
        halted = 1'b0;

        // Reset in the middle of a DM read abandons it.
        $display("[TB] reset during outstanding read");
        applyStimulus(1, 1'b0, 10'd120, '0, 1'b0);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            stepCycle();
            if (dm_gnt) begin
                done = 1'b1;
                dm_req = 1'b0;
            end
        end
        checkOutput("rst_dm_gnt_seen", 32'(done), 32'd1);
        stepCycle();
        checkOutput("rst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_outputs_now", 32'(anyOut()), 32'd0);
        stepCycle();
        stepCycle();
        checkOutput("rst_outputs_held", 32'(anyOut()), 32'd0);
        #2 rst_n = 1'b1;
        sawRv = 1'b0;
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            if (dm_rvalid) sawRv = 1'b1;
        end
        checkOutput("rst_no_dm_rvalid", 32'(sawRv), 32'd0);

`ifdef MEM_ARB_PERF_EN
        // Three DM stores in a row hold fetch off for six cycles.
        $display("[TB] stall counters");
        applyStimulus(2, 1'b0, 10'd16, '0, 1'b1);
        applyStimulus(1, 1'b1, 10'd400, 32'h11, 1'b1);
        n = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            stepCycle();
            if (dm_gnt) begin
                n++;
                if (n < 3) applyStimulus(1, 1'b1, AW'(400 + n), 32'(32'h11 + n), 1'b1);
                else dm_req = 1'b0;
            end
            if (if_gnt) begin
                done = 1'b1;
                if_req = 1'b0;
            end
        end
        stepCycle();
        checkOutput("perf_if_stall", perf_if_stall, 32'd6);
        checkOutput("perf_dm_stall", perf_dm_stall, 32'd0);
`endif

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Arbitrates one single-port synchronous memory between three requesters of the pipelined MIPS32 core: program loader (LD), MEM-stage load/store (DM) and instruction fetch (IF).
- Sits between the core and the unified instruction/data memory, replacing direct array access.
- Provides a fixed-priority grant with a fetch-starvation guard and fixed-latency read return.
- Allows only one memory access in flight at a time.

Parameters:
AW, 10, memory word-address width
DW, 32, data width
MEM_LAT, 1, read latency in cycles from mem_en to valid mem_rdata (1..4)
STARVE_LIM, 4, consecutive denied IF cycles before IF is promoted above DM

Ports:
clk1  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
halted  in  1  core HALTED flag; masks if_req while high
ld_req  in  1  loader write request
ld_addr  in  AW  loader address
ld_wdata  in  DW  loader write data
ld_gnt  out  1  loader grant pulse; write completes this cycle
dm_req  in  1  data request
dm_we  in  1  1=SW, 0=LW
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_gnt  out  1  data grant pulse
dm_rvalid  out  1  load data valid pulse
dm_rdata  out  DW  load data
if_req  in  1  fetch request
if_addr  in  AW  fetch address (PC)
if_gnt  out  1  fetch grant pulse
if_rvalid  out  1  instruction valid pulse
if_rdata  out  DW  instruction word
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  read outstanding

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latency and starvation counters 0; any outstanding read is abandoned with no rvalid.
- FSM states:
  - IDLE: evaluate requests each cycle.
  - RD_WAIT: count MEM_LAT cycles, then return to IDLE.
- Arbitration in IDLE, combinational on registered request inputs; grant, mem_en and the mem_* outputs are registered, and the grant appears the cycle after req is sampled.
  - Priority is LD > DM > IF.
  - If starve_cnt == STARVE_LIM, priority is LD > IF > DM.
- Request rule: requesters hold req, addr, we and wdata stable until their gnt pulse. After gnt, req may drop or present a new request.
- Grant cycle: exactly one *_gnt is high, together with mem_en, and the mem_* outputs carry the winner's fields.
  - ld_gnt always has mem_we=1.
  - if_gnt always has mem_we=0.
- Writes: complete in the grant cycle; FSM stays IDLE, so back-to-back writes on consecutive grant opportunities are allowed.
- Reads: FSM enters RD_WAIT. Exactly MEM_LAT cycles after the grant, the owner's rvalid pulses for one cycle with rdata = mem_rdata. The FSM returns to IDLE in that same cycle, and the next grant is possible in the following cycle.
- Read latency: req-to-rvalid = 1 + MEM_LAT cycles when uncontended.
- busy = (state == RD_WAIT).
- Starvation counter:
  - Increments (saturating at STARVE_LIM) in each IDLE evaluation where if_req && !halted and IF is not the winner.
  - Clears on if_gnt, or when if_req is low or halted is high.
- halted high: IF is never granted. A fetch already granted still returns its rvalid.
- Simultaneous LD and DM: LD wins; DM waits with no limit. The loader is used only pre-run.
- Requests arriving during RD_WAIT are held off and do not change starve_cnt.
- Unused rdata outputs keep their last value; only rvalid qualifies the data.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs perf_if_stall[31:0] and perf_dm_stall[31:0]. These are saturating counts of cycles with if_req&&!halted, and with dm_req respectively, high and not granted. Both reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - requester-ID enum {REQ_NONE, REQ_LD, REQ_DM, REQ_IF}
  - FSM state enum {IDLE, RD_WAIT}
  - constant DW=32
- One sub-module, mips_arb_prio: combinational priority picker. Inputs are the three masked requests plus the starve flag; output is the requester ID.
- Latency counter, owner register and FSM stay in the top level.

Test Plan:
- Loader writes Mem[120]=40 and Mem[240]=80 while if_req is high. Required: two ld_gnt pulses before any if_gnt, each with mem_we=1 and the correct mem_addr/mem_wdata.
- MEM_LAT=1, lone IF read at addr 0 with mem_rdata=32'h28010078. Required: if_gnt at cycle 1, if_rvalid at cycle 2 with if_rdata=32'h28010078, busy high exactly during cycle 2.
- DM LW of addr 120 (data 40) and IF at addr 4 requested in the same cycle. Required: dm_gnt first, dm_rvalid dm_rdata=40, then if_gnt in the cycle after dm_rvalid.
- dm_req held continuously for SW/LW traffic with if_req high and STARVE_LIM=4. Required: if_gnt issued no later than the evaluation after starve_cnt reaches 4; starve_cnt returns to 0 after it.
- halted=1 with if_req=1 for 20 cycles. Required: no if_gnt and starve_cnt stays 0. Then rst_n is pulsed low during RD_WAIT of a DM read. Required: no dm_rvalid, and all outputs 0 immediately on reset.
- With MEM_ARB_PERF_EN defined, 6 contended IF cycles. Required: perf_if_stall=6 and perf_dm_stall=0.
